// File: rtl/cp0_intc.sv
// Coprocessor-0 and interrupt controller: SR/Cause/EPC/PrID/EDGE, pending latch and priority encoder.
// Optional edge-sensitive lines, EDGE register and Cause write-1-to-clear are enabled by macro CP0_EDGE_EN.
module cp0_intc #(
    parameter int          INT_CNT = 6,
    parameter logic [31:0] PRID    = 32'h0000_4D50
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [29:0]        pc,
    input  logic [31:0]        din,
    input  logic [4:0]         sel,
    input  logic               wen,
    input  logic               exl_set,
    input  logic               exl_clr,
    input  logic [INT_CNT-1:0] hw_int,
    output logic               int_req,
    output logic [2:0]         int_id,
    output logic [29:0]        epc,
    output logic [31:0]        dout
);

    localparam logic [4:0] SEL_SR    = 5'd12;
    localparam logic [4:0] SEL_CAUSE = 5'd13;
    localparam logic [4:0] SEL_EPC   = 5'd14;
    localparam logic [4:0] SEL_PRID  = 5'd15;
    localparam logic [4:0] SEL_EDGE  = 5'd16;

    // Lowest set index wins; an empty vector encodes as 0.
    function automatic logic [2:0] prio_enc(input logic [INT_CNT-1:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = INT_CNT - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = 3'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    logic [INT_CNT-1:0] r_im;
    logic               r_ie;
    logic               r_exl;
    logic [INT_CNT-1:0] r_ip;
    logic [2:0]         r_intid;
    logic [29:0]        r_epc;
    logic [INT_CNT-1:0] w_ip_next;
    logic [INT_CNT-1:0] w_active;
    logic [31:0]        w_dout;
    logic               w_wr_sr;
    logic               w_wr_epc;

    assign w_wr_sr  = wen && (sel == SEL_SR);
    assign w_wr_epc = wen && (sel == SEL_EPC);
    assign w_active = r_ip & r_im;

`ifdef CP0_EDGE_EN
    logic [INT_CNT-1:0] r_edge;
    logic [INT_CNT-1:0] r_hw_q;
    logic [INT_CNT-1:0] w_w1c;
    logic [INT_CNT-1:0] w_rise;

    assign w_w1c  = (wen && (sel == SEL_CAUSE)) ? din[INT_CNT+9:10] : '0;
    assign w_rise = hw_int & ~r_hw_q;
    // Edge lines: a new rising edge beats a same-cycle clear; level lines follow the pin.
    assign w_ip_next = (r_edge & ((r_ip & ~w_w1c) | w_rise)) | (~r_edge & hw_int);

    // Edge-mode configuration and input history.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_edge <= '0;
            r_hw_q <= '0;
        end else begin
            r_hw_q <= hw_int;
            if (wen && (sel == SEL_EDGE)) begin
                r_edge <= din[INT_CNT-1:0];
            end
        end
    end
`else
    assign w_ip_next = hw_int;
`endif

    // Pending state, status, cause and exception PC.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_im    <= '0;
            r_ie    <= 1'b0;
            r_exl   <= 1'b0;
            r_ip    <= '0;
            r_intid <= 3'd0;
            r_epc   <= 30'd0;
        end else begin
            r_ip <= w_ip_next;
            if (w_wr_sr) begin
                r_im <= din[INT_CNT+9:10];
                r_ie <= din[0];
            end
            if (exl_set) begin
                r_exl   <= 1'b1;
                r_epc   <= pc;
                r_intid <= prio_enc(w_active);
            end else begin
                if (exl_clr) begin
                    r_exl <= 1'b0;
                end else if (w_wr_sr) begin
                    r_exl <= din[1];
                end
                if (w_wr_epc) begin
                    r_epc <= din[31:2];
                end
            end
        end
    end

    // mfc0 read mux over the current register values.
    always_comb begin
        w_dout = 32'd0;
        case (sel)
            SEL_SR: begin
                w_dout[INT_CNT+9:10] = r_im;
                w_dout[1]            = r_exl;
                w_dout[0]            = r_ie;
            end
            SEL_CAUSE: begin
                w_dout[INT_CNT+9:10] = r_ip;
                w_dout[4:2]          = r_intid;
            end
            SEL_EPC:  w_dout = {r_epc, 2'b00};
            SEL_PRID: w_dout = PRID;
`ifdef CP0_EDGE_EN
            SEL_EDGE: w_dout[INT_CNT-1:0] = r_edge;
`endif
            default:  w_dout = 32'd0;
        endcase
    end

    assign int_req = r_ie & ~r_exl & (|w_active);
    assign int_id  = prio_enc(w_active);
    assign epc     = r_epc;
    assign dout    = w_dout;

endmodule
